dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of the single-port 16-bit data memory.
Shares the memory between port 0 (CPU load/store stage) and port 1 (DMA/debug loader).
Drives the memory's read-enable, write-enable, address and write-data; returns read data with a per-port acknowledge.
Out-of-range addresses are rejected with an error response and never reach the memory.

Parameters:
AW, 16, address width of both ports and the memory
DW, 16, data width
MEM_WORDS, 8192, number of implemented words; any address >= MEM_WORDS is out of range

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
req0  in  1  port 0 request; held high until ack0
we0  in  1  port 0 write (1) / read (0)
addr0  in  AW  port 0 word address
wdata0  in  DW  port 0 write data
ack0  out  1  port 0 completion pulse (one cycle)
err0  out  1  port 0 out-of-range error, valid with ack0
rdata0  out  DW  port 0 read data, valid with ack0 on reads
req1, we1, addr1, wdata1, ack1, err1, rdata1: same as port 0, for port 1
mem_rd  out  1  memory read enable
mem_wr  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, registered by the memory one edge after mem_rd

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. State=IDLE, last_grant=1 (so port 0 wins the first tie). All outputs 0: ack*, err*, rdata*, mem_rd, mem_wr, mem_addr, mem_wdata.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. Each transaction takes 3 cycles; a port can complete at most one transaction every 3 cycles.
- IDLE:
  - If no req, stay in IDLE.
  - Else pick a winner: sole requester wins. If both request, the port != last_grant wins.
  - Latch winner id, we, addr and wdata into internal registers. Set last_grant=winner. Go to ACCESS.
- ACCESS (1 cycle):
  - mem_addr=latched addr, mem_wdata=latched wdata.
  - If in range: mem_rd=!we, mem_wr=we.
  - If out of range: mem_rd=mem_wr=0 and the error flag is latched.
  - Go to RESP.
- RESP (1 cycle):
  - ack of the winner=1.
  - Read, in range: rdata of the winner = mem_rdata (captured by the memory at the ACCESS->RESP edge).
  - Write, or any error: rdata=0.
  - err of the winner = error flag.
  - Go to IDLE.
- Outside RESP: ack*=0, err*=0, rdata*=0. Outside ACCESS: mem_rd=mem_wr=0; mem_addr/mem_wdata hold their last value.
- Invariants:
  - mem_rd and mem_wr are never both 1.
  - At most one ack per cycle.
  - Requests are latched, so changes to addr/wdata/we after IDLE do not affect the transaction in flight.
- Requester rule: after seeing ack, a requester drops req in the following cycle (IDLE). If req is still high there, it counts as a new request.
- The loser's req is held and re-evaluated in the next IDLE. Round-robin bounds its wait to one transaction (max 6 cycles from req to its ACCESS).
- Boundaries:
  - addr = MEM_WORDS-1 is a normal access.
  - addr = MEM_WORDS and addr = 16'hFFFF raise err with no memory strobe.
  - There is no address wrap.
- Reset mid-operation (ACCESS or RESP): next state IDLE, no ack issued, outputs as at reset. A write strobed in ACCESS before the reset edge may have committed.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, ACCESS, RESP); port id constants PORT_CPU=0, PORT_DMA=1; default MEM_WORDS.
- Sub-module rr_arb2: combinational 2-way round-robin pick from (req0, req1, last_grant) -> (grant_valid, grant_id).
- Top module holds the FSM, request latches and output muxing.

Test Plan:
- Port 0 write 16'h1234 @ 0x0005, then read @ 0x0005 -> mem_wr high for exactly 1 cycle, ack0 2 cycles after req; read ack0 with rdata0=16'h1234, err0=0.
- req0 and req1 both raised in the same cycle after reset, both reads -> port 0 granted first (last_grant=1), port 1 acked 3 cycles later. Both held again -> grants alternate 0,1,0,1.
- Port 1 read @ 0x2000 (MEM_WORDS) -> mem_rd/mem_wr stay 0, ack1=1, err1=1, rdata1=0. Read @ 0x1FFF -> err1=0, valid data.
- Port 0 holds req continuously while port 1 requests once -> port 1 acked within 6 cycles. Port 0 is not starved afterwards.
- rst asserted during ACCESS of a port 1 read -> no ack1, all outputs 0 next cycle, state IDLE. A new req0 then completes normally in 3 cycles.
- Random stress: both ports issue random read/write with addresses in 0..8191 against a scoreboard model -> all read data match, mem_rd&mem_wr never both 1, never two acks in one cycle.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int unsigned MEM_WORDS_DEF = 32'd8192;

  // True when a zero-extended word address lies inside the implemented memory.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned words);
    return (addr < words);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick used by the data-memory arbiter.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // Sole requester wins; on a tie the port that was not served last wins.
  always_comb begin
    grant_valid = req0 | req1;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = PORT_DMA;
    end else begin
      grant_id = PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and three-cycle sequencer sharing one single-port data memory
// between the CPU port (0) and the DMA/debug port (1).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          AW        = 16,
  parameter int          DW        = 16,
  parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    state_r;
  arb_state_t    state_s;
  logic          last_grant_r;
  logic          id_r;
  logic          we_r;
  logic          err_r;
  logic          ack0_r;
  logic          ack1_r;
  logic          err0_r;
  logic          err1_r;
  logic          rsel0_r;
  logic          rsel1_r;
  logic          mem_rd_r;
  logic          mem_wr_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;

  logic          grant_valid_s;
  logic          grant_id_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          sel_ok_s;

  rr_arb2 u_rr_arb2 (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant_r),
    .grant_valid (grant_valid_s),
    .grant_id    (grant_id_s)
  );

  // Route the winning port's request fields toward the latches.
  always_comb begin
    if (grant_id_s == PORT_DMA) begin
      sel_we_s    = we1;
      sel_addr_s  = addr1;
      sel_wdata_s = wdata1;
    end else begin
      sel_we_s    = we0;
      sel_addr_s  = addr0;
      sel_wdata_s = wdata0;
    end
  end

  assign sel_ok_s = addr_in_range(32'(sel_addr_s), MEM_WORDS);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_valid_s) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS:  state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request latches, memory strobes and registered per-port responses.
  // Strobes and acks default low so each lives exactly one cycle; the range
  // check is resolved at grant time so an out-of-range access never strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= PORT_DMA;
      id_r         <= PORT_CPU;
      we_r         <= 1'b0;
      err_r        <= 1'b0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      err0_r       <= 1'b0;
      err1_r       <= 1'b0;
      rsel0_r      <= 1'b0;
      rsel1_r      <= 1'b0;
      mem_rd_r     <= 1'b0;
      mem_wr_r     <= 1'b0;
      mem_addr_r   <= {AW{1'b0}};
      mem_wdata_r  <= {DW{1'b0}};
    end else begin
      ack0_r   <= 1'b0;
      ack1_r   <= 1'b0;
      err0_r   <= 1'b0;
      err1_r   <= 1'b0;
      rsel0_r  <= 1'b0;
      rsel1_r  <= 1'b0;
      mem_rd_r <= 1'b0;
      mem_wr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            id_r         <= grant_id_s;
            we_r         <= sel_we_s;
            err_r        <= ~sel_ok_s;
            last_grant_r <= grant_id_s;
            mem_addr_r   <= sel_addr_s;
            mem_wdata_r  <= sel_wdata_s;
            mem_rd_r     <= sel_ok_s & ~sel_we_s;
            mem_wr_r     <= sel_ok_s & sel_we_s;
          end
        end
        ACCESS: begin
          ack0_r  <= (id_r == PORT_CPU);
          ack1_r  <= (id_r == PORT_DMA);
          err0_r  <= (id_r == PORT_CPU) & err_r;
          err1_r  <= (id_r == PORT_DMA) & err_r;
          rsel0_r <= (id_r == PORT_CPU) & ~we_r & ~err_r;
          rsel1_r <= (id_r == PORT_DMA) & ~we_r & ~err_r;
        end
        RESP: begin
          id_r <= id_r;
        end
        default: begin
          id_r <= id_r;
        end
      endcase
    end
  end

  // The memory registers its read data, so it is only valid during RESP.
  assign rdata0    = rsel0_r ? mem_rdata : {DW{1'b0}};
  assign rdata1    = rsel1_r ? mem_rdata : {DW{1'b0}};
  assign ack0      = ack0_r;
  assign ack1      = ack1_r;
  assign err0      = err0_r;
  assign err1      = err1_r;
  assign mem_rd    = mem_rd_r;
  assign mem_wr    = mem_wr_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, round-robin and
// reset sequences, then a two-port random stress run against a scoreboard.
module tb_dmem_arbiter;

  localparam int AW        = 16;
  localparam int DW        = 16;
  localparam int MEM_WORDS = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, we0, ack0, err0;
  logic [15:0]   addr0, wdata0, rdata0;
  logic          req1, we1, ack1, err1;
  logic [15:0]   addr1, wdata1, rdata1;
  logic          mem_rd, mem_wr;
  logic [15:0]   mem_addr, mem_wdata;
  logic [15:0]   mem_rdata = 16'h0000;

  logic [15:0]   mem    [0:MEM_WORDS-1] = '{default: 16'h0000};
  logic [15:0]   shadow [0:MEM_WORDS-1];

  int            errors = 0;
  int            checks = 0;
  int            rd_cnt = 0;
  int            wr_cnt = 0;
  bit            mon_en = 1'b0;

  typedef struct {
    bit          p;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        exp_err;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .err0(err0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .err1(err1), .rdata1(rdata1),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[12:0]] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr[12:0]];
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ctl"},   {26'd0, ack0, err0, ack1, err1, mem_rd, mem_wr}, 32'd0);
    check({pfx, "_rdata"}, {rdata0, rdata1}, 32'd0);
    check({pfx, "_mem"},   {mem_addr, mem_wdata}, 32'd0);
  endtask

  task automatic set_port(input bit p, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d);
    if (p) begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  function automatic logic ack_of(input bit p);
    return p ? ack1 : ack0;
  endfunction

  // One transaction on an otherwise idle bus; inputs are scrambled once granted.
  task automatic txn(input bit p, input logic w, input logic [15:0] a, input logic [15:0] d,
                     output int lat, output logic e, output logic [15:0] rd,
                     output logic [15:0] acc_addr, output logic [15:0] acc_wdata);
    @(negedge clk);
    set_port(p, 1'b1, w, a, d);
    lat = 0; e = 1'b0; rd = 16'h0000; acc_addr = 16'h0000; acc_wdata = 16'h0000;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack_of(p)) break;
      if (lat == 1) begin
        acc_addr  = mem_addr;
        acc_wdata = mem_wdata;
      end
      set_port(p, 1'b1, ~w, ~a, ~d);
    end
    e  = p ? err1 : err0;
    rd = p ? rdata1 : rdata0;
    set_port(p, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic stress_port(input bit p, input int n);
    logic w;
    logic [15:0] a, d;
    int lat;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15))
                                      : 16'($urandom_range(0, MEM_WORDS - 1));
      d = 16'($urandom);
      set_port(p, 1'b1, w, a, d);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!ack_of(p) && lat < 20);
      check("stress_ack", ack_of(p), 1);
      check("stress_wait", lat <= 5, 1);
      if (ack_of(p)) begin
        if (w) shadow[a[12:0]] = d;
        else   check("stress_rdata", p ? rdata1 : rdata0, shadow[a[12:0]]);
        check("stress_err", p ? err1 : err0, 0);
      end
      set_port(p, 1'b0, 1'b0, 16'h0000, 16'h0000);
    end
  endtask

  // Invariant monitor and strobe counters.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("rd_wr_exclusive", mem_rd & mem_wr, 0);
        check("single_ack", ack0 & ack1, 0);
        check("strobe_in_range", (mem_rd | mem_wr) && (mem_addr >= 16'(MEM_WORDS)), 0);
        if (mem_wr) wr_cnt++;
        if (mem_rd) rd_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, w0, r0, a0t, a1t, a0t2, nack;
    logic e;
    logic [15:0] rd, acc_a, acc_d, d0, d1;
    logic exp_wr, exp_rd;
    bit seen;

    vecs[0]  = '{1'b0, 1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234};
    vecs[2]  = '{1'b1, 1'b0, 16'h2000, 16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 16'h1FFF, 16'hBEEF, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h1FFF, 16'h0000, 1'b0, 16'hBEEF};
    vecs[5]  = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000};
    vecs[6]  = '{1'b0, 1'b1, 16'hFFFF, 16'h5555, 1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 1'b1, 16'h0000, 16'hA5A5, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA5A5};
    vecs[9]  = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234};
    vecs[10] = '{1'b0, 1'b1, 16'h2000, 16'h7777, 1'b1, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'hA5A5};

    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      w0 = wr_cnt;
      r0 = rd_cnt;
      exp_wr = vecs[i].we & ~vecs[i].exp_err;
      exp_rd = ~vecs[i].we & ~vecs[i].exp_err;
      txn(vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, e, rd, acc_a, acc_d);
      check($sformatf("vec%0d_latency", i), lat, 2);
      check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_wr_cycles", i), wr_cnt - w0, exp_wr);
      check($sformatf("vec%0d_rd_cycles", i), rd_cnt - r0, exp_rd);
      if (!vecs[i].exp_err) check($sformatf("vec%0d_mem_addr", i), acc_a, vecs[i].addr);
      if (exp_wr) check($sformatf("vec%0d_mem_wdata", i), acc_d, vecs[i].wdata);
    end

    // Simultaneous requests right after reset: port 0 first, port 1 three cycles later.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    set_port(1'b1, 1'b1, 1'b0, 16'h1FFF, 16'h0000);
    a0t = -1; a1t = -1; d0 = 16'h0000; d1 = 16'h0000;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (ack0 && a0t < 0) begin a0t = c; d0 = rdata0; set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000); end
      if (ack1 && a1t < 0) begin a1t = c; d1 = rdata1; set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000); end
      if (a0t >= 0 && a1t >= 0) break;
    end
    check("tie_p0_cycle", a0t, 2);
    check("tie_p1_cycle", a1t, 5);
    check("tie_p0_rdata", d0, 16'h1234);
    check("tie_p1_rdata", d1, 16'hBEEF);

    // Both requests held: grants alternate 0,1,0,1 every three cycles.
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    set_port(1'b1, 1'b1, 1'b0, 16'h1FFF, 16'h0000);
    nack = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack0 | ack1) begin
        if (nack < 4) begin
          check("alt_port", ack1, nack % 2);
          check("alt_cycle", c, 2 + 3 * nack);
        end
        nack++;
      end
    end
    set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("alt_count", nack, 4);

    // Port 0 hogs the bus; port 1 joins once and is served next.
    @(negedge clk);
    set_port(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    @(negedge clk);
    set_port(1'b1, 1'b1, 1'b0, 16'h1FFF, 16'h0000);
    a0t = -1; a0t2 = -1; a1t = -1; d1 = 16'h0000;
    for (int c = 2; c <= 14; c++) begin
      @(negedge clk);
      if (ack1 && a1t < 0) begin a1t = c; d1 = rdata1; set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000); end
      if (ack0) begin
        if (a0t < 0) a0t = c;
        else begin a0t2 = c; set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000); break; end
      end
    end
    set_port(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    check("hog_p0_first", a0t, 2);
    check("hog_p1_cycle", a1t, 5);
    check("hog_p1_rdata", d1, 16'hBEEF);
    check("hog_p0_again", a0t2, 8);

    // Reset during ACCESS of a port 1 read.
    @(negedge clk);
    set_port(1'b1, 1'b1, 1'b0, 16'h1FFF, 16'h0000);
    @(negedge clk);
    check("midrst_access_rd", mem_rd, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    set_port(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack1) seen = 1'b1;
    end
    check("midrst_no_ack1", seen, 0);
    txn(1'b0, 1'b0, 16'h1FFF, 16'h0000, lat, e, rd, acc_a, acc_d);
    check("midrst_p0_latency", lat, 2);
    check("midrst_p0_rdata", rd, 16'hBEEF);
    check("midrst_p0_err", e, 0);

    // Random two-port stress against the scoreboard.
    for (int i = 0; i < MEM_WORDS; i++) shadow[i] = mem[i];
    fork
      stress_port(1'b0, 80);
      stress_port(1'b1, 80);
    join

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
